// File: rtl/ycrcb_pkg.sv
// Shared types and BT.601/BT.709 coefficients for the YCrCb->RGB pipeline.
// Coefficients are stored for a 10-bit fraction and rescaled by the user.
package ycrcb_pkg;

  typedef enum logic {
    MODE_601 = 1'b0,
    MODE_709 = 1'b1
  } mode_e;

  typedef struct packed {
    int ky;
    int krv;
    int kgv;
    int kgu;
    int kbu;
  } coef_t;

  localparam coef_t COEF_601 = '{ky: 1192, krv: 1634, kgv: 832, kgu: 401, kbu: 2065};
  localparam coef_t COEF_709 = '{ky: 1192, krv: 1836, kgv: 546, kgu: 218, kbu: 2163};

  function automatic int scale1(int k, int frac);
    return (frac >= 10) ? (k << (frac - 10)) : (k >> (10 - frac));
  endfunction

  function automatic coef_t coef_scale(coef_t c, int frac);
    coef_t s;
    s.ky  = scale1(c.ky, frac);
    s.krv = scale1(c.krv, frac);
    s.kgv = scale1(c.kgv, frac);
    s.kgu = scale1(c.kgu, frac);
    s.kbu = scale1(c.kbu, frac);
    return s;
  endfunction

endpackage

// File: rtl/ycrcb2rgb_pipe_clamp.sv
// Round-to-nearest, drop fraction bits and saturate a signed accumulator
// into an unsigned DW-bit pixel component.
module ycc_clamp #(
  parameter int DW    = 8,
  parameter int FRAC  = 10,
  parameter int ACC_W = DW + FRAC + 5
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [DW-1:0]    pix
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((1 << DW) - 1);

  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shf;

  always_comb begin
    rnd = acc + HALF;
    shf = rnd >>> FRAC;
    if (shf < 0)
      pix = '0;
    else if (shf > PMAX)
      pix = '1;
    else
      pix = shf[DW-1:0];
  end

endmodule

// File: rtl/ycrcb2rgb_pipe.sv
// Stallable 3-stage YCrCb->RGB converter with per-pixel BT.601/709 select.
// Stages: offset removal, coefficient products, sum + clamp into the output register.
module ycrcb2rgb_pipe
  import ycrcb_pkg::*;
#(
  parameter int DW     = 8,
  parameter int FRAC   = 10,
  parameter int USER_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DW-1:0]     y,
  input  logic [DW-1:0]     cr,
  input  logic [DW-1:0]     cb,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     r,
  output logic [DW-1:0]     g,
  output logic [DW-1:0]     b,
  output logic [USER_W-1:0] out_user
);

  localparam int CW    = FRAC + 3;
  localparam int PW    = DW + 1 + CW;
  localparam int ACC_W = DW + FRAC + 5;
  localparam logic [DW:0] OFS = (DW + 1)'(1) << (DW - 4);
  localparam logic [DW:0] MID = (DW + 1)'(1) << (DW - 1);
  localparam coef_t C601 = coef_scale(COEF_601, FRAC);
  localparam coef_t C709 = coef_scale(COEF_709, FRAC);

  logic adv;

  logic                     v1_q, v1_d;
  mode_e                    mode1_q, mode1_d;
  logic signed [DW:0]       dy1_q, dy1_d, dcr1_q, dcr1_d, dcb1_q, dcb1_d;
  logic [USER_W-1:0]        user1_q, user1_d;

  logic                     v2_q, v2_d;
  logic signed [PW-1:0]     py2_q, py2_d, prv2_q, prv2_d, pgv2_q, pgv2_d;
  logic signed [PW-1:0]     pgu2_q, pgu2_d, pbu2_q, pbu2_d;
  logic [USER_W-1:0]        user2_q, user2_d;

  logic                     out_valid_q, out_valid_d;
  logic [DW-1:0]            r_q, r_d, g_q, g_d, b_q, b_d;
  logic [USER_W-1:0]        out_user_q, out_user_d;

  logic signed [CW-1:0]     ky, krv, kgv, kgu, kbu;
  logic signed [ACC_W-1:0]  sum_r, sum_g, sum_b;
  logic [DW-1:0]            r_c, g_c, b_c;

  // One shared enable: the whole pipe moves or the whole pipe holds.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    v1_d    = v1_q;
    mode1_d = mode1_q;
    dy1_d   = dy1_q;
    dcr1_d  = dcr1_q;
    dcb1_d  = dcb1_q;
    user1_d = user1_q;
    if (adv) begin
      v1_d    = in_valid;
      mode1_d = mode_e'(in_mode);
      dy1_d   = $signed({1'b0, y} - OFS);
      dcr1_d  = $signed({1'b0, cr} - MID);
      dcb1_d  = $signed({1'b0, cb} - MID);
      user1_d = in_user;
    end
  end

  always_comb begin
    ky  = CW'((mode1_q == MODE_709) ? C709.ky  : C601.ky);
    krv = CW'((mode1_q == MODE_709) ? C709.krv : C601.krv);
    kgv = CW'((mode1_q == MODE_709) ? C709.kgv : C601.kgv);
    kgu = CW'((mode1_q == MODE_709) ? C709.kgu : C601.kgu);
    kbu = CW'((mode1_q == MODE_709) ? C709.kbu : C601.kbu);
    v2_d    = v2_q;
    py2_d   = py2_q;
    prv2_d  = prv2_q;
    pgv2_d  = pgv2_q;
    pgu2_d  = pgu2_q;
    pbu2_d  = pbu2_q;
    user2_d = user2_q;
    if (adv) begin
      v2_d    = v1_q;
      py2_d   = PW'(dy1_q)  * PW'(ky);
      prv2_d  = PW'(dcr1_q) * PW'(krv);
      pgv2_d  = PW'(dcr1_q) * PW'(kgv);
      pgu2_d  = PW'(dcb1_q) * PW'(kgu);
      pbu2_d  = PW'(dcb1_q) * PW'(kbu);
      user2_d = user1_q;
    end
  end

  always_comb begin
    sum_r = ACC_W'(py2_q) + ACC_W'(prv2_q);
    sum_g = ACC_W'(py2_q) - ACC_W'(pgv2_q) - ACC_W'(pgu2_q);
    sum_b = ACC_W'(py2_q) + ACC_W'(pbu2_q);
  end

  ycc_clamp #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_clamp_r (.acc(sum_r), .pix(r_c));
  ycc_clamp #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_clamp_g (.acc(sum_g), .pix(g_c));
  ycc_clamp #(.DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) u_clamp_b (.acc(sum_b), .pix(b_c));

  // Output data only changes on a real pixel, so bubbles leave the last pixel visible.
  always_comb begin
    out_valid_d = out_valid_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    out_user_d  = out_user_q;
    if (adv) begin
      out_valid_d = v2_q;
      if (v2_q) begin
        r_d        = r_c;
        g_d        = g_c;
        b_d        = b_c;
        out_user_d = user2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      mode1_q     <= MODE_601;
      dy1_q       <= '0;
      dcr1_q      <= '0;
      dcb1_q      <= '0;
      user1_q     <= '0;
      v2_q        <= 1'b0;
      py2_q       <= '0;
      prv2_q      <= '0;
      pgv2_q      <= '0;
      pgu2_q      <= '0;
      pbu2_q      <= '0;
      user2_q     <= '0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      out_user_q  <= '0;
    end else begin
      v1_q        <= v1_d;
      mode1_q     <= mode1_d;
      dy1_q       <= dy1_d;
      dcr1_q      <= dcr1_d;
      dcb1_q      <= dcb1_d;
      user1_q     <= user1_d;
      v2_q        <= v2_d;
      py2_q       <= py2_d;
      prv2_q      <= prv2_d;
      pgv2_q      <= pgv2_d;
      pgu2_q      <= pgu2_d;
      pbu2_q      <= pbu2_d;
      user2_q     <= user2_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      out_user_q  <= out_user_d;
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign out_user  = out_user_q;

endmodule

// File: tb/tb_ycrcb2rgb_pipe.sv
// Bench for ycrcb2rgb_pipe: a DW=8 and a DW=10 instance, each checked every
// cycle against an integer reference model through an in-order scoreboard.
module tb_ycrcb2rgb_pipe;

  typedef struct packed {
    logic [11:0] r;
    logic [11:0] g;
    logic [11:0] b;
    logic [1:0]  u;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready;
  logic [7:0] a_y, a_cr, a_cb, a_r, a_g, a_b;
  logic [1:0] a_in_user, a_out_user;

  logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
  logic [9:0] b_y, b_cr, b_cb, b_r, b_g, b_b;
  logic [1:0] b_in_user, b_out_user;

  int   nvec = 0;
  int   nmis = 0;
  pix_t aq[$];
  pix_t bq[$];
  pix_t a_last, b_last;

  ycrcb2rgb_pipe #(.DW(8), .FRAC(10), .USER_W(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .y(a_y), .cr(a_cr), .cb(a_cb), .in_user(a_in_user), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .r(a_r), .g(a_g), .b(a_b), .out_user(a_out_user));

  ycrcb2rgb_pipe #(.DW(10), .FRAC(10), .USER_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .y(b_y), .cr(b_cr), .cb(b_cb), .in_user(b_in_user), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .r(b_r), .g(b_g), .b(b_b), .out_user(b_out_user));

  function automatic int clampv(int v, int dw);
    int mx;
    mx = (1 << dw) - 1;
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  // Reference conversion in plain integer arithmetic, FRAC=10 coefficients.
  function automatic pix_t model(int dw, int yy, int cbb, int crr, bit m, logic [1:0] u);
    int krv, kgv, kgu, kbu, dy, dcr, dcb, ty;
    pix_t p;
    if (m) begin krv = 1836; kgv = 546; kgu = 218; kbu = 2163; end
    else   begin krv = 1634; kgv = 832; kgu = 401; kbu = 2065; end
    dy  = yy - (1 << (dw - 4));
    dcr = crr - (1 << (dw - 1));
    dcb = cbb - (1 << (dw - 1));
    ty  = 1192 * dy;
    p.r = 12'(clampv((ty + krv * dcr + 512) >>> 10, dw));
    p.g = 12'(clampv((ty - kgv * dcr - kgu * dcb + 512) >>> 10, dw));
    p.b = 12'(clampv((ty + kbu * dcb + 512) >>> 10, dw));
    p.u = u;
    return p;
  endfunction

  task automatic chk_int(string nm, logic [47:0] got, logic [47:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic chk_pix(string nm, pix_t got, pix_t want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got r=%0d g=%0d b=%0d u=%0d, expected r=%0d g=%0d b=%0d u=%0d",
               nm, got.r, got.g, got.b, got.u, want.r, want.g, want.b, want.u);
    end
  endtask

  always @(negedge clk) begin
    pix_t e, cur;
    if (!rst) begin
      aq.delete();
      bq.delete();
      a_last = '0;
      b_last = '0;
    end else begin
      chk_int("a_ready_rule", 48'(a_in_ready), 48'(!a_out_valid || a_out_ready));
      if (a_in_valid && a_in_ready)
        aq.push_back(model(8, a_y, a_cb, a_cr, a_in_mode, a_in_user));
      cur = '{r: 12'(a_r), g: 12'(a_g), b: 12'(a_b), u: a_out_user};
      if (a_out_valid && a_out_ready) begin
        if (aq.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL a_unexpected_output: got r=%0d g=%0d b=%0d, expected no pixel", a_r, a_g, a_b);
        end else begin
          e = aq.pop_front();
          chk_pix("a_pixel", cur, e);
          a_last = e;
        end
      end else if (!a_out_valid) begin
        chk_pix("a_hold", cur, a_last);
      end

      chk_int("b_ready_rule", 48'(b_in_ready), 48'(!b_out_valid || b_out_ready));
      if (b_in_valid && b_in_ready)
        bq.push_back(model(10, b_y, b_cb, b_cr, b_in_mode, b_in_user));
      cur = '{r: 12'(b_r), g: 12'(b_g), b: 12'(b_b), u: b_out_user};
      if (b_out_valid && b_out_ready) begin
        if (bq.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL b_unexpected_output: got r=%0d g=%0d b=%0d, expected no pixel", b_r, b_g, b_b);
        end else begin
          e = bq.pop_front();
          chk_pix("b_pixel", cur, e);
          b_last = e;
        end
      end else if (!b_out_valid) begin
        chk_pix("b_hold", cur, b_last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_single(string nm, int yy, int cbb, int crr, bit m, int er, int eg, int eb);
    int lat;
    a_y = 8'(yy); a_cb = 8'(cbb); a_cr = 8'(crr); a_in_mode = m; a_in_user = 2'(yy);
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    chk_int({nm, "_in_ready"}, 48'(a_in_ready), 48'd1);
    tick();
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk_int({nm, "_latency"}, 48'(lat), 48'd3);
    chk_int({nm, "_r"}, 48'(a_r), 48'(er));
    chk_int({nm, "_g"}, 48'(a_g), 48'(eg));
    chk_int({nm, "_b"}, 48'(a_b), 48'(eb));
  endtask

  task automatic b_single(string nm, int yy, int cbb, int crr, bit m, int er, int eg, int eb);
    int lat;
    b_y = 10'(yy); b_cb = 10'(cbb); b_cr = 10'(crr); b_in_mode = m; b_in_user = 2'(yy);
    b_in_valid = 1'b1; b_out_ready = 1'b1;
    #1;
    tick();
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk_int({nm, "_latency"}, 48'(lat), 48'd3);
    chk_int({nm, "_r"}, 48'(b_r), 48'(er));
    chk_int({nm, "_g"}, 48'(b_g), 48'(eg));
    chk_int({nm, "_b"}, 48'(b_b), 48'(eb));
  endtask

  task automatic drain_a(string nm);
    int n;
    n = 0;
    while (aq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    chk_int(nm, 48'(aq.size()), 48'd0);
  endtask

  initial begin
    int i, cyc, acc;
    rst = 1'b0;
    a_in_valid = 0; a_in_mode = 0; a_y = 0; a_cr = 0; a_cb = 0; a_in_user = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_mode = 0; b_y = 0; b_cr = 0; b_cb = 0; b_in_user = 0; b_out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk_int("reset_out_valid", 48'(a_out_valid), 48'd0);
    chk_int("reset_rgb", {24'd0, a_r, a_g, a_b}, 48'd0);

    a_single("bt601_a",    72, 130, 173, 1'b0, 137,  28,  69);
    a_single("bt601_b",    98, 184,  93, 1'b0,  40, 102, 208);
    a_single("black",      16, 128, 128, 1'b0,   0,   0,   0);
    a_single("neg_clamp",   0, 128, 128, 1'b0,   0,   0,   0);
    a_single("pos_clamp", 235,  16, 240, 1'b0, 255, 208,  29);
    a_single("bt709_a",    72, 130, 173, 1'b1, 146,  41,  69);

    // Same pixel with mode flipping every cycle.
    for (int k = 0; k < 8; k++) begin
      a_y = 8'd72; a_cb = 8'd130; a_cr = 8'd173; a_in_mode = k[0]; a_in_user = 2'(k);
      a_in_valid = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    drain_a("mode_switch_drain");

    // Reset while the pipe is full and input is still offered.
    for (int k = 0; k < 5; k++) begin
      a_y = 8'(100 + 20 * k); a_cb = 8'd90; a_cr = 8'd200; a_in_mode = 1'b0; a_in_user = 2'(k);
      a_in_valid = 1'b1;
      tick();
    end
    rst = 1'b0;
    #1;
    chk_int("midreset_out_valid", 48'(a_out_valid), 48'd0);
    chk_int("midreset_rgb", {24'd0, a_r, a_g, a_b}, 48'd0);
    tick();
    tick();
    rst = 1'b1;
    a_in_valid = 1'b0;
    repeat (4) tick();
    a_single("post_reset", 98, 184, 93, 1'b0, 40, 102, 208);

    // Back-pressure: random out_ready plus a 5-cycle hold low.
    i = 0; cyc = 0;
    while ((i < 8 || aq.size() != 0) && cyc < 300) begin
      a_out_ready = (cyc >= 4 && cyc < 9) ? 1'b0 : 1'($urandom_range(0, 1));
      a_in_valid  = (i < 8);
      a_y = 8'($urandom_range(0, 255)); a_cb = 8'($urandom_range(0, 255));
      a_cr = 8'($urandom_range(0, 255)); a_in_mode = 1'($urandom_range(0, 1));
      a_in_user = 2'(i);
      #1;
      if (a_in_valid && a_in_ready) i++;
      tick();
      cyc++;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    chk_int("bp_all_sent", 48'(i), 48'd8);
    chk_int("bp_all_received", 48'(aq.size()), 48'd0);

    b_single("dw10", 288, 520, 692, 1'b0, 548, 111, 277);

    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_y = 10'($urandom_range(0, 1023)); b_cb = 10'($urandom_range(0, 1023));
      b_cr = 10'($urandom_range(0, 1023)); b_in_mode = 1'($urandom_range(0, 1));
      b_in_user = 2'($urandom_range(0, 3));
      #1;
      if (b_in_valid && b_in_ready) acc++;
      tick();
      cyc++;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    cyc = 0;
    while (bq.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk_int("dw10_random_count", 48'(acc), 48'd10000);
    chk_int("dw10_random_drain", 48'(bq.size()), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
